mipicsi2_elastbuf_lvl: RTL and testbench

- Parametrised successor to the shift-register elasticity buffer in the CSI-2 device datapath.
- Any depth of 2 or more, with a registered occupancy count.
- Programmable almost-full and almost-empty thresholds.
- Well-defined simultaneous read/write at full and at empty, plus sticky overflow/underflow error flags.
- Sits between the lane-merge/deskew stage and the packet parser to absorb short-term rate mismatch.

---
 rtl/mipicsi2_elastbuf_lvl.sv | 137 +++++++++++++
 tb/tb_mipicsi2_elastbuf_lvl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mipicsi2_elastbuf_lvl.sv
// mipicsi2_elastbuf_lvl
// First-word-fall-through elasticity buffer between lane-merge/deskew and the
// packet parser. Storage is a shift register with entry 0 as the head, so
// dataout needs no read pointer and entries at or above count stay zero.
// Status flags decode the registered count. Overflow and underflow are
// recorded in sticky error flags.
module mipicsi2_elastbuf_lvl #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = $clog2(DEPTH + 1),
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] datain,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] dataout,
  input  logic                  clrbuff,
  input  logic                  clr_err,
  output logic                  emptyz,
  output logic                  fullz,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_W-1:0]      count,
  output logic                  ovf_err,
  output logic                  udf_err
);

  localparam logic [CNT_W-1:0]      LP_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      LP_AF    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0]      LP_AE    = CNT_W'(AE_LEVEL);
  localparam logic [CNT_W-1:0]      LP_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]      LP_CZERO = {CNT_W{1'b0}};
  localparam logic [DATA_WIDTH-1:0] LP_DZERO = {DATA_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0] r_mem     [DEPTH];
  logic [DATA_WIDTH-1:0] w_mem_up  [DEPTH];
  logic [DATA_WIDTH-1:0] w_mem_nxt [DEPTH];
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      w_count_nxt;
  logic [CNT_W-1:0]      w_widx;
  logic                  r_ovf;
  logic                  r_udf;
  logic                  w_ovf_nxt;
  logic                  w_udf_nxt;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_ovf_evt;
  logic                  w_udf_evt;

  // A flush swallows the cycle's read and write, so no events are raised then.
  assign w_empty   = (r_count == LP_CZERO);
  assign w_full    = (r_count == LP_DEPTH);
  assign w_pop     = read & ~w_empty & ~clrbuff;
  // At full a write is only accepted when a pop frees the head slot.
  assign w_push    = write & ~clrbuff & (~w_full | w_pop);
  assign w_ovf_evt = write & ~read & w_full & ~clrbuff;
  assign w_udf_evt = read & w_empty & ~clrbuff;
  // When popping, everything moves down one slot, so the tail slot is count-1.
  assign w_widx    = w_pop ? (r_count - LP_ONE) : r_count;

  // Shifted-down view of storage used by a pop; the top slot refills with zero.
  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      w_mem_up[i] = r_mem[i + 1];
    end
    w_mem_up[DEPTH-1] = LP_DZERO;
  end

  // Next storage contents: flush, then write at the tail, then shift or hold.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (clrbuff) begin
        w_mem_nxt[i] = LP_DZERO;
      end else if (w_push && (w_widx == CNT_W'(i))) begin
        w_mem_nxt[i] = datain;
      end else if (w_pop) begin
        w_mem_nxt[i] = w_mem_up[i];
      end else begin
        w_mem_nxt[i] = r_mem[i];
      end
    end
  end

  // Next occupancy: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    w_count_nxt = r_count;
    if (clrbuff) begin
      w_count_nxt = LP_CZERO;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + LP_ONE;
        2'b01:   w_count_nxt = r_count - LP_ONE;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Sticky error flags; a new event beats a same-cycle clear.
  always_comb begin
    w_ovf_nxt = w_ovf_evt | (r_ovf & ~clr_err);
    w_udf_nxt = w_udf_evt | (r_udf & ~clr_err);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= LP_CZERO;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= LP_DZERO;
      end
    end else begin
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
      r_udf   <= w_udf_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= w_mem_nxt[i];
      end
    end
  end

  assign dataout      = r_mem[0];
  assign count        = r_count;
  assign emptyz       = ~w_empty;
  assign fullz        = ~w_full;
  assign almost_full  = (r_count >= LP_AF);
  assign almost_empty = (r_count <= LP_AE);
  assign ovf_err      = r_ovf;
  assign udf_err      = r_udf;

endmodule

// File: tb/tb_mipicsi2_elastbuf_lvl.sv
// Bench for mipicsi2_elastbuf_lvl. Instance A (DEPTH=4, AF=3, AE=1) runs a
// table of directed vectors. Instance B (DEPTH=5, AF=4, AE=2) runs random
// traffic checked against a queue model, with a reset injected mid-stream.
module tb_mipicsi2_elastbuf_lvl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic       a_rst, a_wr, a_rd, a_clr, a_cerr;
  logic [7:0] a_din, a_dout;
  logic [2:0] a_cnt;
  logic       a_ez, a_fz, a_af, a_ae, a_ovf, a_udf;

  // Instance B signals
  logic       b_rst, b_wr, b_rd, b_clr, b_cerr;
  logic [7:0] b_din, b_dout;
  logic [2:0] b_cnt;
  logic       b_ez, b_fz, b_af, b_ae, b_ovf, b_udf;

  mipicsi2_elastbuf_lvl #(.DEPTH(4), .DATA_WIDTH(8)) u_dut_a (
    .clk(clk), .rst(a_rst), .write(a_wr), .datain(a_din), .read(a_rd),
    .dataout(a_dout), .clrbuff(a_clr), .clr_err(a_cerr), .emptyz(a_ez),
    .fullz(a_fz), .almost_full(a_af), .almost_empty(a_ae), .count(a_cnt),
    .ovf_err(a_ovf), .udf_err(a_udf)
  );

  mipicsi2_elastbuf_lvl #(.DEPTH(5), .DATA_WIDTH(8), .AF_LEVEL(4), .AE_LEVEL(2)) u_dut_b (
    .clk(clk), .rst(b_rst), .write(b_wr), .datain(b_din), .read(b_rd),
    .dataout(b_dout), .clrbuff(b_clr), .clr_err(b_cerr), .emptyz(b_ez),
    .fullz(b_fz), .almost_full(b_af), .almost_empty(b_ae), .count(b_cnt),
    .ovf_err(b_ovf), .udf_err(b_udf)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ctl = {rst, write, read, clrbuff, clr_err}; fl = {emptyz, fullz, af, ae, ovf, udf}
  typedef struct {
    logic [4:0] ctl;
    logic [7:0] din;
    logic [7:0] dout;
    logic [2:0] cnt;
    logic [5:0] fl;
  } vec_t;

  vec_t tbl[$];

  // Queue reference model for instance B (depth 5, AF 4, AE 2)
  localparam int BD = 5;
  logic [7:0] q[$];
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;

  task automatic model_step(input bit rst, input bit wr, input bit rd,
                            input bit clr, input bit cerr, input logic [7:0] din);
    int  sz;
    bit  eo;
    bit  eu;
    logic [7:0] tmp;
    sz = q.size();
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else if (clr) begin
      q.delete();
      if (cerr) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
    end else begin
      eo = wr && !rd && (sz == BD);
      eu = rd && (sz == 0);
      if (rd && sz > 0) begin
        tmp = q.pop_front();
        if (wr) q.push_back(din);
      end else if (wr && sz < BD) begin
        q.push_back(din);
      end
      m_ovf = eo | (m_ovf & !cerr);
      m_udf = eu | (m_udf & !cerr);
    end
  endtask

  task automatic check_b(input string tag);
    int sz;
    sz = q.size();
    chk({tag, "_dout"}, {24'd0, b_dout}, (sz > 0) ? {24'd0, q[0]} : 32'd0);
    chk({tag, "_cnt"},  {29'd0, b_cnt},  sz);
    chk({tag, "_ez"},   {31'd0, b_ez},   (sz != 0) ? 32'd1 : 32'd0);
    chk({tag, "_fz"},   {31'd0, b_fz},   (sz != BD) ? 32'd1 : 32'd0);
    chk({tag, "_af"},   {31'd0, b_af},   (sz >= 4) ? 32'd1 : 32'd0);
    chk({tag, "_ae"},   {31'd0, b_ae},   (sz <= 2) ? 32'd1 : 32'd0);
    chk({tag, "_ovf"},  {31'd0, b_ovf},  {31'd0, m_ovf});
    chk({tag, "_udf"},  {31'd0, b_udf},  {31'd0, m_udf});
  endtask

  initial begin
    {a_rst, a_wr, a_rd, a_clr, a_cerr} = 5'b10000;
    a_din = 8'h00;
    {b_rst, b_wr, b_rd, b_clr, b_cerr} = 5'b10000;
    b_din = 8'h00;

    // Directed vectors for instance A
    tbl.push_back('{5'b10000, 8'h00, 8'h00, 3'd0, 6'b010100}); // reset
    tbl.push_back('{5'b01000, 8'h11, 8'h11, 3'd1, 6'b110100});
    tbl.push_back('{5'b01000, 8'h22, 8'h11, 3'd2, 6'b110000});
    tbl.push_back('{5'b01000, 8'h33, 8'h11, 3'd3, 6'b111000});
    tbl.push_back('{5'b01000, 8'h44, 8'h11, 3'd4, 6'b101000}); // full
    tbl.push_back('{5'b00100, 8'h00, 8'h22, 3'd3, 6'b111000});
    tbl.push_back('{5'b00100, 8'h00, 8'h33, 3'd2, 6'b110000});
    tbl.push_back('{5'b00100, 8'h00, 8'h44, 3'd1, 6'b110100});
    tbl.push_back('{5'b00100, 8'h00, 8'h00, 3'd0, 6'b010100}); // empty
    tbl.push_back('{5'b01000, 8'h11, 8'h11, 3'd1, 6'b110100});
    tbl.push_back('{5'b01000, 8'h22, 8'h11, 3'd2, 6'b110000});
    tbl.push_back('{5'b01000, 8'h33, 8'h11, 3'd3, 6'b111000});
    tbl.push_back('{5'b01000, 8'h44, 8'h11, 3'd4, 6'b101000});
    tbl.push_back('{5'b01000, 8'h55, 8'h11, 3'd4, 6'b101010}); // overflow
    tbl.push_back('{5'b01100, 8'h66, 8'h22, 3'd4, 6'b101010}); // rd+wr at full
    tbl.push_back('{5'b00100, 8'h00, 8'h33, 3'd3, 6'b111010});
    tbl.push_back('{5'b00100, 8'h00, 8'h44, 3'd2, 6'b110010});
    tbl.push_back('{5'b00100, 8'h00, 8'h66, 3'd1, 6'b110110}); // 0x66 was tail
    tbl.push_back('{5'b00100, 8'h00, 8'h00, 3'd0, 6'b010110});
    tbl.push_back('{5'b00001, 8'h00, 8'h00, 3'd0, 6'b010100}); // clr_err
    tbl.push_back('{5'b01100, 8'hA5, 8'hA5, 3'd1, 6'b110101}); // rd+wr at empty
    tbl.push_back('{5'b01000, 8'h01, 8'hA5, 3'd2, 6'b110001});
    tbl.push_back('{5'b01000, 8'h02, 8'hA5, 3'd3, 6'b111001});
    tbl.push_back('{5'b01010, 8'h03, 8'h00, 3'd0, 6'b010101}); // clrbuff + write
    tbl.push_back('{5'b00000, 8'h00, 8'h00, 3'd0, 6'b010101});
    tbl.push_back('{5'b00001, 8'h00, 8'h00, 3'd0, 6'b010100}); // clr_err
    tbl.push_back('{5'b00101, 8'h00, 8'h00, 3'd0, 6'b010101}); // event beats clear
    tbl.push_back('{5'b00001, 8'h00, 8'h00, 3'd0, 6'b010100});

    for (int k = 0; k < tbl.size(); k++) begin
      {a_rst, a_wr, a_rd, a_clr, a_cerr} = tbl[k].ctl;
      a_din = tbl[k].din;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_dout", k), {24'd0, a_dout}, {24'd0, tbl[k].dout});
      chk($sformatf("row%0d_cnt", k),  {29'd0, a_cnt},  {29'd0, tbl[k].cnt});
      chk($sformatf("row%0d_ez", k),   {31'd0, a_ez},   {31'd0, tbl[k].fl[5]});
      chk($sformatf("row%0d_fz", k),   {31'd0, a_fz},   {31'd0, tbl[k].fl[4]});
      chk($sformatf("row%0d_af", k),   {31'd0, a_af},   {31'd0, tbl[k].fl[3]});
      chk($sformatf("row%0d_ae", k),   {31'd0, a_ae},   {31'd0, tbl[k].fl[2]});
      chk($sformatf("row%0d_ovf", k),  {31'd0, a_ovf},  {31'd0, tbl[k].fl[1]});
      chk($sformatf("row%0d_udf", k),  {31'd0, a_udf},  {31'd0, tbl[k].fl[0]});
    end
    {a_rst, a_wr, a_rd, a_clr, a_cerr} = 5'b00000;

    // Random traffic on instance B against the queue model
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int ph;
      int pw;
      int pr;
      ph = (cyc / 150) % 4;
      if (ph == 0) begin
        pw = 75; pr = 30;
      end else if (ph == 1) begin
        pw = 30; pr = 75;
      end else if (ph == 2) begin
        pw = 50; pr = 50;
      end else begin
        pw = 90; pr = 90;
      end
      b_rst  = (cyc == 0) || (cyc == 1000);
      b_wr   = ($urandom_range(0, 99) < pw);
      b_rd   = ($urandom_range(0, 99) < pr);
      b_clr  = ($urandom_range(0, 79) == 0);
      b_cerr = ($urandom_range(0, 29) == 0);
      b_din  = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      model_step(b_rst, b_wr, b_rd, b_clr, b_cerr, b_din);
      if (cyc == 1000) begin
        chk("midrst_cnt",  {29'd0, b_cnt},  32'd0);
        chk("midrst_dout", {24'd0, b_dout}, 32'd0);
        chk("midrst_ez",   {31'd0, b_ez},   32'd0);
        chk("midrst_fz",   {31'd0, b_fz},   32'd1);
        chk("midrst_ae",   {31'd0, b_ae},   32'd1);
        chk("midrst_af",   {31'd0, b_af},   32'd0);
        chk("midrst_ovf",  {31'd0, b_ovf},  32'd0);
        chk("midrst_udf",  {31'd0, b_udf},  32'd0);
      end else begin
        check_b($sformatf("rnd%0d", cyc));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
